// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the data-memory load/store engine.
package mem_access_unit_pkg;

  localparam int ADDR_WIDTH = 32;

  // {is_store, funct3}
  typedef enum logic [3:0] {
    OP_LB  = 4'b0000,
    OP_LH  = 4'b0001,
    OP_LW  = 4'b0010,
    OP_LBU = 4'b0100,
    OP_LHU = 4'b0101,
    OP_SB  = 4'b1000,
    OP_SH  = 4'b1001,
    OP_SW  = 4'b1010
  } mem_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_ERR,
    ST_DONE
  } mau_state_t;

  // True when the op is a known encoding and the address suits its size.
  function automatic logic access_ok(input logic [3:0] op, input logic [1:0] lo);
    logic legal;
    logic aligned;
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: legal = 1'b1;
      default:                                                  legal = 1'b0;
    endcase
    case (op[1:0])
      2'b01:   aligned = ~lo[0];
      2'b10:   aligned = (lo == 2'b00);
      default: aligned = 1'b1;
    endcase
    return legal & aligned;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Execute-stage request/response channel of the load/store engine.
interface mem_access_unit_if
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = mem_access_unit_pkg::ADDR_WIDTH
);
  // A request transfers on a rising edge where req_i and ready_o are both high;
  // valid_o is a one-cycle completion pulse qualifying rdata_o and err_o.
  logic                  req_i;
  logic                  ready_o;
  logic [3:0]            op_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [31:0]           wdata_i;
  logic                  valid_o;
  logic [31:0]           rdata_o;
  logic                  err_o;
  mau_state_t            state_o;

  modport master (
    output req_i, op_i, addr_i, wdata_i,
    input  ready_o, valid_o, rdata_o, err_o, state_o
  );

  modport slave (
    input  req_i, op_i, addr_i, wdata_i,
    output ready_o, valid_o, rdata_o, err_o, state_o
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte/half lane handling: load extract + extend, and store merge into a read word.
module mem_lane_align (
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);
  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = word_i >> {lane_i, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      3'b000:  load_o = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_o = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_o = {24'h0, byte_sel};
      3'b101:  load_o = {16'h0, half_sel};
      default: load_o = word_i;
    endcase

    // Untouched lanes keep the word that was just read.
    merge_o = word_i;
    case (funct3_i)
      3'b000:  merge_o[{lane_i, 3'b000} +: 8]        = wdata_i[7:0];
      3'b001:  merge_o[{lane_i[1], 4'b0000} +: 16]   = wdata_i[15:0];
      default: merge_o = wdata_i;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store bus initiator: one request at a time, word-aligned bus, RMW for SB/SH.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = mem_access_unit_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_access_unit_if.slave      exe,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  inout  wire  [31:0]           mem_bus_io
);
  mau_state_t              state_q;
  logic                    ready_q, valid_q, err_q, mem_re_q, mem_we_q;
  logic [31:0]             rdata_q, wdata_q;
  logic [3:0]              op_q;
  logic [1:0]              lane_q;
  logic [ADDR_WIDTH-1:2]   word_addr_q;
  logic [31:0]             load_word, merge_word;

  mem_lane_align u_align (
    .funct3_i (op_q[2:0]),
    .lane_i   (lane_q),
    .word_i   (mem_bus_io),
    .wdata_i  (wdata_q),
    .load_o   (load_word),
    .merge_o  (merge_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      wdata_q     <= 32'h0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      op_q        <= 4'h0;
      lane_q      <= 2'b00;
      word_addr_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (exe.req_i) begin
            ready_q     <= 1'b0;
            op_q        <= exe.op_i;
            lane_q      <= exe.addr_i[1:0];
            word_addr_q <= exe.addr_i[ADDR_WIDTH-1:2];
            wdata_q     <= exe.wdata_i;
            if (!access_ok(exe.op_i, exe.addr_i[1:0])) begin
              state_q <= ST_ERR;
            end else if (exe.op_i == OP_SW) begin
              state_q  <= ST_WR;
              mem_we_q <= 1'b1;
            end else begin
              state_q  <= ST_RD;
              mem_re_q <= 1'b1;
            end
          end
        end
        ST_RD: begin
          mem_re_q <= 1'b0;
          if (op_q[3]) begin
            wdata_q  <= merge_word;
            mem_we_q <= 1'b1;
            state_q  <= ST_WR;
          end else begin
            rdata_q <= load_word;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_WR: begin
          mem_we_q <= 1'b0;
          rdata_q  <= 32'h0;
          err_q    <= 1'b0;
          valid_q  <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_ERR: begin
          rdata_q <= 32'h0;
          err_q   <= 1'b1;
          valid_q <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          mem_re_q <= 1'b0;
          mem_we_q <= 1'b0;
          ready_q  <= 1'b1;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign exe.ready_o = ready_q;
  assign exe.valid_o = valid_q;
  assign exe.rdata_o = rdata_q;
  assign exe.err_o   = err_q;
  assign exe.state_o = state_q;

  assign mem_addr_o  = {word_addr_q, 2'b00};
  assign mem_re_o    = mem_re_q;
  assign mem_we_o    = mem_we_q;
  assign mem_bus_io  = mem_we_q ? wdata_q : 32'bz;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized bench for mem_access_unit against a byte-arithmetic memory model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;
  localparam int AW = ADDR_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_WIDTH(AW)) exe_if ();
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we;
  wire  [31:0]   mem_bus;

  mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .exe        (exe_if),
    .mem_addr_o (mem_addr),
    .mem_re_o   (mem_re),
    .mem_we_o   (mem_we),
    .mem_bus_io (mem_bus)
  );

  // ---------------- environment memory (combinational read) ----------------
  logic [31:0] tb_mem [0:63];
  logic        pl_we = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_val = 32'h0;

  assign mem_bus = mem_re ? tb_mem[mem_addr[7:2]] : 32'bz;
  always @(posedge clk) begin
    if (mem_we)     tb_mem[mem_addr[7:2]] <= mem_bus;
    else if (pl_we) tb_mem[pl_idx] <= pl_val;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:63];

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                                output bit err, output logic [31:0] rd, output logic [31:0] nw,
                                output int lat, output bit rph, output bit wph);
    int f3, nbytes, off;
    bit legal;
    logic [31:0] word, mask, v;
    f3     = int'(op[2:0]);
    off    = int'(a % 4);
    nbytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    legal  = op[3] ? (f3 <= 2) : (f3 != 3 && f3 != 6 && f3 != 7);
    word   = ref_mem[a[7:2]];
    nw = word; rd = 32'h0; rph = 0; wph = 0; lat = 2; err = 0;
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
    if (!legal || (off % nbytes) != 0) begin
      err = 1;
      return;
    end
    if (!op[3]) begin
      rph = 1;
      v = (word >> (8 * off)) & mask;
      if (f3 < 4 && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
      rd = v;
    end else begin
      wph = 1;
      if (nbytes == 4) nw = wd;
      else begin
        rph = 1;
        lat = 3;
        nw = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      end
      ref_mem[a[7:2]] = nw;
    end
  endfunction

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    pl_idx = idx; pl_val = val; pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // ---------------- driver + monitor ----------------
  // Called just after a falling edge; returns just after the falling edge following DONE.
  task automatic do_req(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, output logic [31:0] got_rd);
    bit e_err, e_rph, e_wph;
    logic [31:0] e_rd, e_new, bus_val;
    int e_lat, re_cnt, we_cnt, re_cyc, we_cyc, v_cyc, k;
    logic got_err;
    model(op, a, wd, e_err, e_rd, e_new, e_lat, e_rph, e_wph);
    exe_if.req_i = 1'b1; exe_if.op_i = op; exe_if.addr_i = a; exe_if.wdata_i = wd;
    k = 0;
    while (!exe_if.ready_o && k < 20) begin @(negedge clk); k++; end
    check({name, "_ready_wait"}, 32'(exe_if.ready_o), 32'd1);
    @(negedge clk);
    if (!hold) exe_if.req_i = 1'b0;
    re_cnt = 0; we_cnt = 0; re_cyc = 0; we_cyc = 0; v_cyc = 0;
    bus_val = 32'h0; got_rd = 32'h0; got_err = 1'b0;
    for (int c = 1; c <= 8 && v_cyc == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_re) begin re_cnt++; re_cyc = c; end
      if (mem_we) begin we_cnt++; we_cyc = c; bus_val = mem_bus; end
      if (mem_re || mem_we) check({name, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
      if (exe_if.valid_o) begin
        v_cyc = c; got_rd = exe_if.rdata_o; got_err = exe_if.err_o;
        check({name, "_ready_in_done"}, 32'(exe_if.ready_o), 32'd0);
      end
    end
    check({name, "_latency"}, 32'(v_cyc), 32'(e_lat));
    check({name, "_rdata"}, got_rd, e_rd);
    check({name, "_err"}, 32'(got_err), 32'(e_err));
    check({name, "_re_cycles"}, 32'(re_cnt), 32'(e_rph));
    check({name, "_we_cycles"}, 32'(we_cnt), 32'(e_wph));
    if (e_rph) check({name, "_re_at"}, 32'(re_cyc), 32'd1);
    if (e_wph) begin
      check({name, "_we_at"}, 32'(we_cyc), e_rph ? 32'd2 : 32'd1);
      check({name, "_bus_word"}, bus_val, e_new);
    end
    @(negedge clk);
    check({name, "_valid_one_cycle"}, 32'(exe_if.valid_o), 32'd0);
    check({name, "_ready_after"}, 32'(exe_if.ready_o), 32'd1);
    check({name, "_mem_word"}, tb_mem[a[7:2]], ref_mem[a[7:2]]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] r;
    logic [31:0] w;
    logic [3:0]  rop;
    logic [31:0] ra;
    int v_seen;
    exe_if.req_i = 1'b0; exe_if.op_i = 4'h0; exe_if.addr_i = '0; exe_if.wdata_i = 32'h0;

    @(negedge clk);
    check("rst_ready", 32'(exe_if.ready_o), 32'd1);
    check("rst_valid", 32'(exe_if.valid_o), 32'd0);
    check("rst_err", 32'(exe_if.err_o), 32'd0);
    check("rst_rdata", exe_if.rdata_o, 32'h0);
    check("rst_re", 32'(mem_re), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_state", 32'(exe_if.state_o), 32'(ST_IDLE));

    for (int i = 0; i < 64; i++) preload(6'(i), $urandom);
    preload(6'd4, 32'h8899AABC);
    preload(6'd5, 32'h13579BDF);
    rst_n = 1'b1;
    @(negedge clk);

    do_req("lb13", OP_LB, 32'h13, 32'h0, 1'b0, r);   check("lb13_value", r, 32'hFFFFFF88);
    do_req("lhu12", OP_LHU, 32'h12, 32'h0, 1'b0, r); check("lhu12_value", r, 32'h00008899);
    do_req("lh10", OP_LH, 32'h10, 32'h0, 1'b0, r);   check("lh10_value", r, 32'hFFFFAABC);
    do_req("lbu11", OP_LBU, 32'h11, 32'h0, 1'b0, r); check("lbu11_value", r, 32'h000000AA);
    do_req("lw10", OP_LW, 32'h10, 32'h0, 1'b0, r);   check("lw10_value", r, 32'h8899AABC);
    do_req("sb11", OP_SB, 32'h11, 32'h12345655, 1'b0, r);
    check("sb11_word", tb_mem[4], 32'h889955BC);
    do_req("lw10_rb", OP_LW, 32'h10, 32'h0, 1'b0, r); check("lw10_rb_value", r, 32'h889955BC);
    do_req("sw02_mis", OP_SW, 32'h02, 32'hCAFEF00D, 1'b0, r);
    check("sw02_mem0", tb_mem[0], ref_mem[0]);
    do_req("ld011_ill", 4'b0011, 32'h10, 32'h0, 1'b0, r);

    // SH interrupted by reset while the write cycle is on the bus
    w = ~ref_mem[5];
    exe_if.req_i = 1'b1; exe_if.op_i = OP_SH; exe_if.addr_i = 32'h14; exe_if.wdata_i = w;
    check("rstmid_ready", 32'(exe_if.ready_o), 32'd1);
    @(negedge clk);
    exe_if.req_i = 1'b0;
    check("rstmid_rd", 32'(mem_re), 32'd1);
    @(negedge clk);
    check("rstmid_wr", 32'(mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("rstmid_we_async", 32'(mem_we), 32'd0);
    check("rstmid_re_async", 32'(mem_re), 32'd0);
    #1 rst_n = 1'b1;
    v_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (exe_if.valid_o) v_seen++;
    end
    check("rstmid_no_valid", 32'(v_seen), 32'd0);
    check("rstmid_ready_after", 32'(exe_if.ready_o), 32'd1);
    check("rstmid_word14", tb_mem[5], 32'h13579BDF);

    // back-to-back with req_i held high across the gap
    do_req("sw20", OP_SW, 32'h20, 32'hDEADBEEF, 1'b1, r);
    do_req("lw20", OP_LW, 32'h20, 32'h0, 1'b0, r);
    check("lw20_value", r, 32'hDEADBEEF);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 32'($urandom_range(0, 255));
      do_req($sformatf("rnd%0d", i), rop, ra, $urandom, ($urandom_range(0, 1) == 1), r);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
